mul_accum: RTL
==============

Name: mul_accum

Overview:
- Sequential stage directly downstream of the combinational multiplier; consumes its DATAWIDTH-bit product and accumulates a fixed number of products into one sum.
- Sum arithmetic wraps modulo 2^DATAWIDTH, matching the multiplier's truncation.
- The completed sum is presented on a valid/ready output port. A sticky overflow flag reports any carry-out within the batch.
- Used to build dot-product/MAC datapaths from the generated netlist components.

Parameters:
- DATAWIDTH, 64, width of incoming product and of outgoing sum.
- COUNT, 4, number of accepted products per result; legal range 1..255.
- CNTWIDTH, 8, width of internal term counter; must satisfy 2^CNTWIDTH > COUNT.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous active-high reset.
- prod  input  DATAWIDTH  product from upstream multiplier.
- in_valid  input  1  prod is valid this cycle.
- in_ready  output  1  block accepts prod this cycle.
- clr  input  1  synchronous abort of the partial batch.
- sum  output  DATAWIDTH  completed accumulation result.
- ovf  output  1  a carry-out occurred during the batch that produced sum.
- out_valid  output  1  sum/ovf valid.
- out_ready  input  1  downstream consumes sum this cycle.

Behaviour:
- Interface: one clock Clk; reset Rst is synchronous and active-high. Rst overrides every other input.
- Reset values:
  - sum=0, ovf=0, out_valid=0, in_ready=1.
  - Internal acc=0, acc_ovf=0, term count=0, state=ACCUM.
- States: ACCUM and HOLD. All outputs are registered or decoded from the state only; there is no combinational path from in_valid or out_ready to in_ready.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - A term is accepted when in_valid=1, and only then.
  - On accept with count<COUNT-1: acc<=acc+prod (low DATAWIDTH bits); acc_ovf<=acc_ovf OR carry-out; count<=count+1.
  - On accept with count==COUNT-1:
    - sum<=acc+prod; ovf<=acc_ovf OR carry.
    - acc<=0, acc_ovf<=0, count<=0.
    - State goes to HOLD. out_valid=1 starting the next cycle; latency from the final accept to out_valid is 1 cycle.
  - A cycle with in_valid=0 leaves all state unchanged; gaps between terms are allowed.
- HOLD:
  - in_ready=0 and out_valid=1; in_valid is ignored.
  - sum and ovf stay stable until a handshake.
  - When out_ready=1: the next cycle has out_valid=0, in_ready=1, state=ACCUM.
  - sum/ovf keep their last value after the handshake and are don't-care once out_valid=0.
  - At least one bubble cycle separates consecutive results; no accept occurs in the handshake cycle.
- clr:
  - In ACCUM: acc, acc_ovf and count are zeroed next cycle. A same-cycle in_valid term is discarded and does not count.
  - In HOLD: ignored; the pending result is preserved.
- COUNT=1: every accepted prod goes straight to HOLD with sum=prod and ovf=0.
- Rst asserted mid-batch or in HOLD: the partial batch and pending result are lost; outputs return to reset values next cycle.
- Wrap-around: the counter never exceeds COUNT-1. The sum is always the low DATAWIDTH bits of the true total.

Test Plan:
1. DATAWIDTH=8, COUNT=4; Rst for 2 cycles; accept prod=2,3,5,7 on consecutive cycles -> in the cycle after the 4th accept, out_valid=1, sum=17, ovf=0, in_ready=0.
2. Same batch, out_ready=0 for 5 cycles while in_valid=1 with prod=9 -> sum holds 17, in_ready=0, no term absorbed. Raise out_ready -> next cycle out_valid=0, in_ready=1; then 1,1,1,1 gives sum=4.
3. DATAWIDTH=8, terms 200,100,0,0 -> sum=44, ovf=1. The following batch 1,2,3,4 -> sum=10, ovf=0 (sticky flag clears per batch).
4. Accept 5,6; then clr=1 with in_valid=1, prod=50; then accept 1,1,1,1 -> sum=4 (clr and the 50 dropped).
5. Enter HOLD with sum=17; assert Rst for 1 cycle -> next cycle out_valid=0, sum=0, ovf=0, in_ready=1. A fresh batch 3,3,3,3 -> sum=12.
6. COUNT=1, in_valid pulses with 1-cycle gaps, prod=0xAA,0x55 -> each produces out_valid one cycle after accept with sum=0xAA then 0x55. out_ready held high gives one bubble between results.

Source files
------------

// File: rtl/mul_accum.sv
// -----------------------------------------------------------------------------
// mul_accum
//   Accumulates COUNT consecutive products from the upstream multiplier into
//   one DATAWIDTH-bit sum (modulo 2^DATAWIDTH). The finished sum is offered on
//   a valid/ready port. A sticky flag reports whether any add in that batch
//   carried out of the top bit.
//
// Ports
//   Clk        rising-edge clock
//   Rst        synchronous active-high reset, overrides every other input
//   prod       product from upstream multiplier
//   in_valid   prod is valid this cycle
//   in_ready   block accepts prod this cycle (decoded from state only)
//   clr        synchronous abort of the partial batch (ignored while holding)
//   sum        completed accumulation result
//   ovf        a carry-out occurred during the batch that produced sum
//   out_valid  sum/ovf valid
//   out_ready  downstream consumes sum this cycle
// -----------------------------------------------------------------------------
module mul_accum #(
  parameter int DATAWIDTH = 64,
  parameter int COUNT     = 4,
  parameter int CNTWIDTH  = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] prod,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clr,
  output logic [DATAWIDTH-1:0] sum,
  output logic                 ovf,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Index of the final term of a batch
  localparam logic [CNTWIDTH-1:0] LAST_C = CNTWIDTH'(COUNT - 1);

  state_t               state_r;
  logic [DATAWIDTH-1:0] acc_r;
  logic                 acc_ovf_r;
  logic [CNTWIDTH-1:0]  cnt_r;
  logic [DATAWIDTH-1:0] sum_r;
  logic                 ovf_r;
  logic                 out_valid_r;
  logic                 in_ready_r;

  logic [DATAWIDTH:0]   add_s;
  logic [DATAWIDTH-1:0] add_lo_s;
  logic                 carry_s;

  // One extra bit on the adder exposes the carry-out of acc + prod
  always_comb begin
    add_s    = {1'b0, acc_r} + {1'b0, prod};
    add_lo_s = add_s[DATAWIDTH-1:0];
    carry_s  = add_s[DATAWIDTH];
  end

  // Batch accumulation, result hold and output handshake
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r     <= ACCUM;
      acc_r       <= {DATAWIDTH{1'b0}};
      acc_ovf_r   <= 1'b0;
      cnt_r       <= {CNTWIDTH{1'b0}};
      sum_r       <= {DATAWIDTH{1'b0}};
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        ACCUM: begin
          if (clr) begin
            // Abort wins over a same-cycle term, which is dropped
            acc_r     <= {DATAWIDTH{1'b0}};
            acc_ovf_r <= 1'b0;
            cnt_r     <= {CNTWIDTH{1'b0}};
          end else if (in_valid) begin
            if (cnt_r == LAST_C) begin
              sum_r       <= add_lo_s;
              ovf_r       <= acc_ovf_r | carry_s;
              acc_r       <= {DATAWIDTH{1'b0}};
              acc_ovf_r   <= 1'b0;
              cnt_r       <= {CNTWIDTH{1'b0}};
              state_r     <= HOLD;
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
            end else begin
              acc_r     <= add_lo_s;
              acc_ovf_r <= acc_ovf_r | carry_s;
              cnt_r     <= cnt_r + {{(CNTWIDTH-1){1'b0}}, 1'b1};
            end
          end else begin
            acc_r <= acc_r;
          end
        end
        HOLD: begin
          // Handshake cycle never accepts a term: in_ready is already low
          if (out_ready) begin
            state_r     <= ACCUM;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r     <= ACCUM;
          acc_r       <= {DATAWIDTH{1'b0}};
          acc_ovf_r   <= 1'b0;
          cnt_r       <= {CNTWIDTH{1'b0}};
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign sum       = sum_r;
  assign ovf       = ovf_r;
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;

endmodule
